// File: rtl/foc_pkg.sv
// Shared FOC constants, FSM states and fixed-point helpers.
// Used by the Clarke/Park stage, the PI stage and inverse Park.
package foc_pkg;

  localparam int CUR_W   = 12;
  localparam int TRIG_W  = 16;
  localparam int FRAC    = 15;
  localparam int OUT_MAX = 2047;
  localparam int I_MAX   = OUT_MAX;

  localparam logic [15:0] K_INV_SQRT3 = 16'd18919;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BETA,
    S_P0,
    S_P1,
    S_P2,
    S_P3,
    S_RND,
    S_OUT
  } cp_state_t;

  // Q15 round half up: add 2^14, shift right by 15.
  function automatic logic signed [16:0] round_q15(
    input logic signed [30:0] x
  );
    logic signed [31:0] y;
    y = {x[30], x} + 32'sd16384;
    return y[31:15];
  endfunction

  // Symmetric clip, -2048 is never produced.
  function automatic logic signed [11:0] sat_cur(
    input logic signed [16:0] x
  );
    if (x > 17'sd2047)
      return 12'sd2047;
    if (x < -17'sd2047)
      return -12'sd2047;
    return x[11:0];
  endfunction

endpackage

// File: rtl/foc_mult_14x16.sv
// Combinational signed 14x16 multiplier (one DSP slice).
// Ports: a (14b signed), b (16b signed), p (30b signed product).
module foc_mult_14x16 (
  input  logic signed [13:0] a,
  input  logic signed [15:0] b,
  output logic signed [29:0] p
);

  assign p = $signed(30'(a)) * $signed(30'(b));

endmodule

// File: rtl/clarke_park_transform.sv
// Clarke + Park transform on one shared multiplier, FSM driven.
// In: iClk, iRst, ia/ib, sin/cos, iCal_en. Out: id, iq, done pulse.
module clarke_park_transform
  import foc_pkg::*;
(
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic signed [CUR_W-1:0]  iCurrent_a,
  input  logic signed [CUR_W-1:0]  iCurrent_b,
  input  logic signed [TRIG_W-1:0] iSin,
  input  logic signed [TRIG_W-1:0] iCos,
  input  logic                     iCal_en,
  output logic signed [CUR_W-1:0]  oCurrent_d,
  output logic signed [CUR_W-1:0]  oCurrent_q,
  output logic                     oCal_done
);

  cp_state_t state;

  logic               en_prev;
  logic               start;
  logic signed [11:0] ia_r;
  logic signed [15:0] sin_r;
  logic signed [15:0] cos_r;
  logic signed [13:0] sum;
  logic signed [12:0] alpha;
  logic signed [12:0] beta;
  logic signed [30:0] acc;
  logic signed [30:0] acc_d;
  logic signed [30:0] acc_q;
  logic signed [16:0] rnd_d;
  logic signed [16:0] rnd_q;
  logic signed [16:0] beta_rnd;

  logic signed [13:0] mul_a;
  logic signed [15:0] mul_b;
  logic signed [29:0] prod;
  logic signed [30:0] prod_x;

  assign start    = iCal_en & ~en_prev;
  assign prod_x   = {prod[29], prod};
  assign beta_rnd = round_q15(prod_x);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      S_BETA: begin
        mul_a = sum;
        mul_b = K_INV_SQRT3;
      end
      S_P0: begin
        mul_a = {alpha[12], alpha};
        mul_b = cos_r;
      end
      S_P1: begin
        mul_a = {beta[12], beta};
        mul_b = sin_r;
      end
      S_P2: begin
        mul_a = {alpha[12], alpha};
        mul_b = sin_r;
      end
      S_P3: begin
        mul_a = {beta[12], beta};
        mul_b = cos_r;
      end
      default: ;
    endcase
  end

  foc_mult_14x16 u_mult (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= S_IDLE;
      en_prev    <= 1'b0;
      ia_r       <= '0;
      sin_r      <= '0;
      cos_r      <= '0;
      sum        <= '0;
      alpha      <= '0;
      beta       <= '0;
      acc        <= '0;
      acc_d      <= '0;
      acc_q      <= '0;
      rnd_d      <= '0;
      rnd_q      <= '0;
      oCurrent_d <= '0;
      oCurrent_q <= '0;
      oCal_done  <= 1'b0;
    end else begin
      en_prev   <= iCal_en;
      oCal_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            ia_r  <= iCurrent_a;
            sin_r <= iSin;
            cos_r <= iCos;
            // ia + 2*ib, fits 14 bits for 12-bit inputs
            sum   <= {{2{iCurrent_a[11]}}, iCurrent_a}
                   + {iCurrent_b[11], iCurrent_b, 1'b0};
            state <= S_BETA;
          end
        end
        S_BETA: begin
          beta  <= beta_rnd[12:0];
          alpha <= {ia_r[11], ia_r};
          state <= S_P0;
        end
        S_P0: begin
          acc   <= prod_x;
          state <= S_P1;
        end
        S_P1: begin
          acc_d <= acc + prod_x;
          state <= S_P2;
        end
        S_P2: begin
          acc   <= -prod_x;
          state <= S_P3;
        end
        S_P3: begin
          acc_q <= acc + prod_x;
          state <= S_RND;
        end
        S_RND: begin
          rnd_d <= round_q15(acc_d);
          rnd_q <= round_q15(acc_q);
          state <= S_OUT;
        end
        S_OUT: begin
          oCurrent_d <= sat_cur(rnd_d);
          oCurrent_q <= sat_cur(rnd_q);
          oCal_done  <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clarke_park_transform.sv
// Self-checking bench for clarke_park_transform.
// Directed, random, retrigger and reset-abort scenarios.
module tb_clarke_park_transform;

  logic               iClk;
  logic               iRst;
  logic signed [11:0] iCurrent_a;
  logic signed [11:0] iCurrent_b;
  logic signed [15:0] iSin;
  logic signed [15:0] iCos;
  logic               iCal_en;
  logic signed [11:0] oCurrent_d;
  logic signed [11:0] oCurrent_q;
  logic               oCal_done;

  int pass_cnt;
  int total_cnt;

  clarke_park_transform dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iCurrent_a (iCurrent_a),
    .iCurrent_b (iCurrent_b),
    .iSin       (iSin),
    .iCos       (iCos),
    .iCal_en    (iCal_en),
    .oCurrent_d (oCurrent_d),
    .oCurrent_q (oCurrent_q),
    .oCal_done  (oCal_done)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic longint rnd15(input longint x);
    return (x + 64'sd16384) >>> 15;
  endfunction

  function automatic int clip(input longint x);
    if (x > 2047) return 2047;
    if (x < -2047) return -2047;
    return int'(x);
  endfunction

  // id = alpha*cos + beta*sin, iq = beta*cos - alpha*sin
  task automatic model(input int a, input int b, input int s,
                       input int c, output int d, output int q);
    longint alpha, beta;
    alpha = a;
    beta  = rnd15(longint'(a + 2 * b) * 18919);
    d = clip(rnd15(alpha * c + beta * s));
    q = clip(rnd15(beta * c - alpha * s));
  endtask

  task automatic run_conv(input int a, input int b, input int s,
                          input int c, output int lat);
    iCal_en = 1'b0;
    @(posedge iClk); #1;
    iCurrent_a = 12'(a);
    iCurrent_b = 12'(b);
    iSin = 16'(s);
    iCos = 16'(c);
    iCal_en = 1'b1;
    @(posedge iClk); #1;
    iCal_en = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge iClk); #1;
      if (oCal_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_conv(input string nm, input int a, input int b,
                            input int s, input int c);
    int lat, ed, eq;
    model(a, b, s, c, ed, eq);
    run_conv(a, b, s, c, lat);
    total_cnt++;
    if (lat !== 7)
      $display("FAIL %s latency got %0d want 7", nm, lat);
    else pass_cnt++;
    total_cnt++;
    if (int'(oCurrent_d) !== ed)
      $display("FAIL %s d got %0d want %0d", nm, oCurrent_d, ed);
    else pass_cnt++;
    total_cnt++;
    if (int'(oCurrent_q) !== eq)
      $display("FAIL %s q got %0d want %0d", nm, oCurrent_q, eq);
    else pass_cnt++;
    @(posedge iClk); #1;
    total_cnt++;
    if (oCal_done !== 1'b0)
      $display("FAIL %s done_width got %b want 0", nm, oCal_done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    iCal_en = 1'b0;
    iCurrent_a = '0;
    iCurrent_b = '0;
    iSin = '0;
    iCos = '0;
    repeat (3) @(posedge iClk);
    #1;
    total_cnt++;
    if (oCurrent_d !== 12'sd0 || oCurrent_q !== 12'sd0 ||
        oCal_done !== 1'b0)
      $display("FAIL reset got d=%0d q=%0d done=%b want 0 0 0",
               oCurrent_d, oCurrent_q, oCal_done);
    else pass_cnt++;
    iRst = 1'b0;
  endtask

  task automatic test_directed();
    check_conv("theta0", 1000, -500, 0, 32767);
    check_conv("theta90", 1000, -500, 32767, 0);
    check_conv("beta_path", 0, 1000, 0, 32767);
    check_conv("sat_pos", 2047, 2047, 0, 32767);
    check_conv("sat_neg", -2048, -2048, 0, 32767);
    total_cnt++;
    if (oCurrent_d !== -12'sd2047 || oCurrent_q !== -12'sd2047)
      $display("FAIL sat_neg_const got %0d %0d want -2047 -2047",
               oCurrent_d, oCurrent_q);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int a, b, s, c;
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(4095)) - 2048;
      b = int'($urandom_range(4095)) - 2048;
      s = int'($urandom_range(65535)) - 32768;
      c = int'($urandom_range(65535)) - 32768;
      check_conv("random", a, b, s, c);
    end
  endtask

  task automatic test_retrigger();
    int ed, eq, first, pulses;
    model(700, 300, 12000, 28000, ed, eq);
    iCal_en = 1'b0;
    @(posedge iClk); #1;
    iCurrent_a = 12'sd700;
    iCurrent_b = 12'sd300;
    iSin = 16'sd12000;
    iCos = 16'sd28000;
    iCal_en = 1'b1;
    @(posedge iClk); #1;
    iCal_en = 1'b0;
    first = -1;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin
        iCurrent_a = -12'sd1500;
        iCurrent_b = 12'sd900;
        iSin = -16'sd20000;
        iCos = 16'sd5000;
        iCal_en = 1'b1;
      end
      if (i == 5) iCal_en = 1'b0;
      @(posedge iClk); #1;
      if (oCal_done) begin
        pulses++;
        if (first < 0) begin
          first = i;
          total_cnt++;
          if (int'(oCurrent_d) !== ed || int'(oCurrent_q) !== eq)
            $display("FAIL retrig_data got %0d %0d want %0d %0d",
                     oCurrent_d, oCurrent_q, ed, eq);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (pulses !== 1 || first !== 7)
      $display("FAIL retrig_pulse got n=%0d at %0d want n=1 at 7",
               pulses, first);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int ed, eq, lat, early;
    model(-900, 1200, -16000, 25000, ed, eq);
    iCal_en = 1'b0;
    @(posedge iClk); #1;
    iCurrent_a = -12'sd900;
    iCurrent_b = 12'sd1200;
    iSin = -16'sd16000;
    iCos = 16'sd25000;
    iCal_en = 1'b1;
    @(posedge iClk); #1;
    early = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge iClk); #1;
      if (oCal_done) early++;
    end
    iRst = 1'b1;
    @(posedge iClk); #1;
    total_cnt++;
    if (oCurrent_d !== 12'sd0 || oCurrent_q !== 12'sd0 ||
        oCal_done !== 1'b0 || early !== 0)
      $display("FAIL abort got d=%0d q=%0d done=%b early=%0d want 0",
               oCurrent_d, oCurrent_q, oCal_done, early);
    else pass_cnt++;
    iRst = 1'b0;
    @(posedge iClk); #1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge iClk); #1;
      if (oCal_done) begin
        lat = i;
        break;
      end
    end
    iCal_en = 1'b0;
    total_cnt++;
    if (lat !== 7)
      $display("FAIL restart_lat got %0d want 7", lat);
    else pass_cnt++;
    total_cnt++;
    if (int'(oCurrent_d) !== ed || int'(oCurrent_q) !== eq)
      $display("FAIL restart_data got %0d %0d want %0d %0d",
               oCurrent_d, oCurrent_q, ed, eq);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
    test_random();
    test_retrigger();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
